dice_roller: RTL

Pseudo-random dice source for the snakes-and-ladders game engine. It answers the engine's roll requests with a die value 1..6 over a valid/ack handshake, tags each result with the requesting player, and applies the "six grants an extra turn, third consecutive six forfeits" rule. It sits between the free-running clock domain and the game FSM, which acts as the initiator.

---
 rtl/dice_pkg.sv | 23 ++
 rtl/lfsr16.sv | 37 +++
 rtl/dice_roller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// Shared definitions for the dice roller.
//   state_e       : roller FSM state encoding (IDLE=0, DRAW=1, PRESENT=2)
//   LFSR_MASK     : Galois feedback mask of the 16-bit right-shifting LFSR
//   DIE_MIN/MAX   : legal die face bounds
//   lfsr_next()   : one LFSR step
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAW    = 2'd1,
        PRESENT = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [2:0]  DIE_MIN   = 3'd1;
    localparam logic [2:0]  DIE_MAX   = 3'd6;

    // Right shift; the bit shifted out selects whether the mask is folded in.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR.
//   clk   : rising-edge clock; the register steps on every edge
//   reset : asynchronous active-low; loads SEED (or 16'h0001 if SEED is 0)
//   rnd_o : low three bits of the current state, used as the raw die draw
module lfsr16
    import dice_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] rnd_o
);

    // An all-zero state would lock the LFSR, so a zero seed is replaced.
    localparam logic [15:0] LOAD_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next-state step of the LFSR.
    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    // LFSR state register with seed load on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LOAD_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd_o = lfsr_q[2:0];

endmodule

// File: rtl/dice_roller.sv
// Dice source for the game engine: answers roll requests with a value 1..6
// over a valid/ack handshake and tracks consecutive sixes per player.
//   clk, reset       : clock and asynchronous active-low reset
//   roll_req, player : request (level) and requesting player, taken in IDLE
//   roll_ack         : engine consumed the result, taken in PRESENT
//   roll_valid       : result held until acknowledged
//   roll_val         : die value 1..6, 0 when not valid
//   roll_player      : player latched with the request
//   extra_turn       : a six that is not the third consecutive one
//   forfeit          : third consecutive six by this player
module dice_roller
    import dice_pkg::*;
#(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          MAX_REJ = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       roll_req,
    input  logic       player,
    input  logic       roll_ack,
    output logic       roll_valid,
    output logic [2:0] roll_val,
    output logic       roll_player,
    output logic       extra_turn,
    output logic       forfeit
);

    localparam int              REJ_W     = (MAX_REJ < 1) ? 1 : $clog2(MAX_REJ + 1);
    localparam logic [REJ_W-1:0] REJ_LIMIT = REJ_W'(MAX_REJ);

    logic [2:0]       rnd_s;
    logic             accept_s;
    logic [2:0]       draw_val_s;

    state_e           state_q, state_d;
    logic [REJ_W-1:0] rej_cnt_q, rej_cnt_d;
    logic [1:0][1:0]  six_cnt_q, six_cnt_d;
    logic             roll_valid_q, roll_valid_d;
    logic [2:0]       roll_val_q, roll_val_d;
    logic             roll_player_q, roll_player_d;
    logic             extra_turn_q, extra_turn_d;
    logic             forfeit_q, forfeit_d;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .rnd_o (rnd_s)
    );

    // Judge the current draw: a legal face is taken as-is; after MAX_REJ
    // rejects a 0/7 draw is folded into 1..4 so latency stays bounded.
    always_comb begin
        accept_s   = 1'b0;
        draw_val_s = 3'd0;
        if (rnd_s >= DIE_MIN && rnd_s <= DIE_MAX) begin
            accept_s   = 1'b1;
            draw_val_s = rnd_s;
        end else if (rej_cnt_q >= REJ_LIMIT) begin
            accept_s   = 1'b1;
            draw_val_s = {1'b0, rnd_s[1:0]} + 3'd1;
        end else begin
            accept_s   = 1'b0;
            draw_val_s = 3'd0;
        end
    end

    // FSM next state, handshake outputs and per-player six tracking.
    always_comb begin
        state_d       = state_q;
        rej_cnt_d     = rej_cnt_q;
        six_cnt_d     = six_cnt_q;
        roll_valid_d  = roll_valid_q;
        roll_val_d    = roll_val_q;
        roll_player_d = roll_player_q;
        extra_turn_d  = extra_turn_q;
        forfeit_d     = forfeit_q;
        case (state_q)
            IDLE: begin
                if (roll_req) begin
                    roll_player_d = player;
                    rej_cnt_d     = {REJ_W{1'b0}};
                    state_d       = DRAW;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAW: begin
                if (accept_s) begin
                    state_d      = PRESENT;
                    roll_valid_d = 1'b1;
                    roll_val_d   = draw_val_s;
                    // roll_player_q already holds the requester here.
                    if (draw_val_s == DIE_MAX) begin
                        if (six_cnt_q[roll_player_q] == 2'd2) begin
                            forfeit_d                = 1'b1;
                            extra_turn_d             = 1'b0;
                            six_cnt_d[roll_player_q] = 2'd0;
                        end else begin
                            forfeit_d                = 1'b0;
                            extra_turn_d             = 1'b1;
                            six_cnt_d[roll_player_q] = six_cnt_q[roll_player_q] + 2'd1;
                        end
                    end else begin
                        forfeit_d                = 1'b0;
                        extra_turn_d             = 1'b0;
                        six_cnt_d[roll_player_q] = 2'd0;
                    end
                end else begin
                    rej_cnt_d = rej_cnt_q + REJ_W'(1);
                end
            end
            PRESENT: begin
                if (roll_ack) begin
                    state_d      = IDLE;
                    roll_valid_d = 1'b0;
                    roll_val_d   = 3'd0;
                    extra_turn_d = 1'b0;
                    forfeit_d    = 1'b0;
                end else begin
                    state_d = PRESENT;
                end
            end
            default: begin
                state_d      = IDLE;
                roll_valid_d = 1'b0;
                roll_val_d   = 3'd0;
                extra_turn_d = 1'b0;
                forfeit_d    = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            rej_cnt_q     <= {REJ_W{1'b0}};
            six_cnt_q     <= '0;
            roll_valid_q  <= 1'b0;
            roll_val_q    <= 3'd0;
            roll_player_q <= 1'b0;
            extra_turn_q  <= 1'b0;
            forfeit_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rej_cnt_q     <= rej_cnt_d;
            six_cnt_q     <= six_cnt_d;
            roll_valid_q  <= roll_valid_d;
            roll_val_q    <= roll_val_d;
            roll_player_q <= roll_player_d;
            extra_turn_q  <= extra_turn_d;
            forfeit_q     <= forfeit_d;
        end
    end

    assign roll_valid  = roll_valid_q;
    assign roll_val    = roll_val_q;
    assign roll_player = roll_player_q;
    assign extra_turn  = extra_turn_q;
    assign forfeit     = forfeit_q;

endmodule
